// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and related blocks.
package uart_pkg;

  localparam int BYTESIZES_DEFAULT = 8;

  localparam logic HDR_MSB_MARKER = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    SEND,
    GAP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search: the first asserted request at or
// above the pointer wins, wrapping around past the top index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               found_o,
  output logic [IDW-1:0]     idx_o
);

  logic [NUM_REQ-1:0] rotated;
  int                 offset;
  int                 pos;

  // Rotate requests so the pointer sits at bit 0, take the lowest set bit, then map back.
  always_comb begin
    rotated = NUM_REQ'({req_i, req_i} >> ptr_i);
    grant_o = '0;
    found_o = 1'b0;
    offset  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found_o = 1'b1;
        offset  = k;
      end
    end
    pos = int'(ptr_i) + offset;
    if (pos >= NUM_REQ) begin
      pos = pos - NUM_REQ;
    end
    idx_o = IDW'(pos);
    for (int j = 0; j < NUM_REQ; j++) begin
      grant_o[j] = found_o && (idx_o == IDW'(j));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between several byte requesters.
// Latches the winning byte, drives the uart_tx handshake, waits for the rising
// edge of the frame-done level, enforces an inter-frame gap and aborts stalled
// frames after a timeout.
// Optional build macro UART_TX_ARB_ID_PREFIX_EN: each grant first sends a header
// byte carrying the requester index (HDR), then a one-cycle LOAD, then the payload.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BYTESIZES      = BYTESIZES_DEFAULT,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid_in,
  input  logic [NUM_REQ*BYTESIZES-1:0] req_data_in,
  output logic [NUM_REQ-1:0]           req_ready_out,
  output logic                         tx_valid_out,
  output logic [BYTESIZES-1:0]         tx_data_out,
  input  logic                         tx_done_in,
  output logic [IDW-1:0]               grant_id_out,
  output logic                         busy_out,
  output logic                         timeout_err_out
);

  localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_TERM  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int GAP_TERM = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

`ifdef UART_TX_ARB_ID_PREFIX_EN
  localparam arb_state_t FIRST_STATE = HDR;
`else
  localparam arb_state_t FIRST_STATE = SEND;
`endif

  arb_state_t           state_q, state_d;
  logic [IDW-1:0]       rrPtr_q;
  logic [IDW-1:0]       grantId_q;
  logic [BYTESIZES-1:0] txData_q;
  logic [NUM_REQ-1:0]   reqReady_q;
  logic                 timeoutErr_q;
  logic                 txDone_q;
  logic [TW-1:0]        toCnt_q;
  logic [GW-1:0]        gapCnt_q;

  logic [NUM_REQ-1:0]   winGrant;
  logic                 winFound;
  logic [IDW-1:0]       winIdx;
  logic [BYTESIZES-1:0] winData;
  logic [IDW-1:0]       nextPtr;
  logic                 doneRise;
  logic                 toTerm;
  logic                 gapTerm;
  logic                 inFrame;
  logic                 grantEv;
  logic                 timeoutEv;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_rr (
    .req_i  (req_valid_in),
    .ptr_i  (rrPtr_q),
    .grant_o(winGrant),
    .found_o(winFound),
    .idx_o  (winIdx)
  );

  assign doneRise  = tx_done_in & ~txDone_q;
  assign toTerm    = (toCnt_q == TW'(TO_TERM));
  assign gapTerm   = (gapCnt_q == GW'(GAP_TERM));
  assign inFrame   = (state_q == HDR) || (state_q == SEND);
  assign grantEv   = (state_q == IDLE) && winFound;
  assign timeoutEv = inFrame && toTerm && !doneRise;

  // Select the winner's byte and the pointer position just past the winner.
  always_comb begin
    winData = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winIdx == IDW'(j)) begin
        winData = req_data_in[j*BYTESIZES +: BYTESIZES];
      end
    end
    nextPtr = (winIdx == IDW'(NUM_REQ - 1)) ? '0 : winIdx + IDW'(1);
  end

`ifdef UART_TX_ARB_ID_PREFIX_EN
  logic [BYTESIZES-1:0] payload_q;
  logic [BYTESIZES-1:0] hdrByte;

  // Header byte is the zero-extended requester index with the marker bit on top.
  always_comb begin
    hdrByte                = BYTESIZES'(winIdx);
    hdrByte[BYTESIZES-1]   = HDR_MSB_MARKER;
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done edge beats the timeout when both land together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (winFound) state_d = FIRST_STATE;
      HDR: begin
        if (doneRise) begin
          state_d = LOAD;
        end else if (toTerm) begin
          state_d = GAP;
        end
      end
      LOAD: state_d = SEND;
      SEND: begin
        if (doneRise || toTerm) begin
          state_d = GAP;
        end
      end
      GAP: if (gapTerm) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    tx_valid_out = inFrame;
    busy_out     = (state_q != IDLE);
  end

  assign req_ready_out   = reqReady_q;
  assign tx_data_out     = txData_q;
  assign grant_id_out    = grantId_q;
  assign timeout_err_out = timeoutErr_q;

  // Grant bookkeeping, byte latch, done-edge history and the two saturating counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      rrPtr_q      <= '0;
      grantId_q    <= '0;
      txData_q     <= '0;
      reqReady_q   <= '0;
      timeoutErr_q <= 1'b0;
      txDone_q     <= 1'b0;
      toCnt_q      <= '0;
      gapCnt_q     <= '0;
`ifdef UART_TX_ARB_ID_PREFIX_EN
      payload_q    <= '0;
`endif
    end else begin
      txDone_q     <= tx_done_in;
      reqReady_q   <= '0;
      timeoutErr_q <= timeoutEv;
      if (grantEv) begin
        reqReady_q <= winGrant;
        grantId_q  <= winIdx;
        rrPtr_q    <= nextPtr;
`ifdef UART_TX_ARB_ID_PREFIX_EN
        txData_q   <= hdrByte;
        payload_q  <= winData;
`else
        txData_q   <= winData;
`endif
      end
`ifdef UART_TX_ARB_ID_PREFIX_EN
      if ((state_q == HDR) && doneRise) begin
        txData_q <= payload_q;
      end
`endif
      if (inFrame) begin
        if (!toTerm) begin
          toCnt_q <= toCnt_q + TW'(1);
        end
      end else begin
        toCnt_q <= '0;
      end
      if (state_q == GAP) begin
        if (!gapTerm) begin
          gapCnt_q <= gapCnt_q + GW'(1);
        end
      end else begin
        gapCnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// request patterns, checked against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int B   = 8;
  localparam int GAP = 16;
  localparam int TO  = 50;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid_in;
  logic [N*B-1:0] req_data_in;
  logic [N-1:0]   req_ready_out;
  logic           tx_valid_out;
  logic [B-1:0]   tx_data_out;
  logic           tx_done_in;
  logic [1:0]     grant_id_out;
  logic           busy_out;
  logic           timeout_err_out;

  int           checks   = 0;
  int           failures = 0;
  int           mPtr     = 0;
  logic [N-1:0] curMask  = '0;
  logic [B-1:0] mData [N];

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .BYTESIZES     (B),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid_in   (req_valid_in),
    .req_data_in    (req_data_in),
    .req_ready_out  (req_ready_out),
    .tx_valid_out   (tx_valid_out),
    .tx_data_out    (tx_data_out),
    .tx_done_in     (tx_done_in),
    .grant_id_out   (grant_id_out),
    .busy_out       (busy_out),
    .timeout_err_out(timeout_err_out)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Hard stop in case the clocked flow ever wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask);
    curMask      = mask;
    req_valid_in = mask;
    for (int i = 0; i < N; i++) begin
      req_data_in[i*B +: B] = mData[i];
    end
  endtask

  // Reference arbitration: first valid index at or above the pointer, with wrap.
  function automatic int pickWinner(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [B-1:0] firstByte(input int w);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    return 8'h80 | B'(w);
`else
    return mData[w];
`endif
  endfunction

  task automatic grantStep(input logic [N-1:0] mask, input bit dropAfter, output int w, output logic [B-1:0] payload);
    logic [N-1:0] m;
    m = mask;
    applyStimulus(m);
    w = pickWinner(m, mPtr);
    checkOutput("pre_grant_idle", 32'(busy_out), 0);
    tick();
    if (w < 0) begin
      checkOutput("no_req_no_ready", 32'(req_ready_out), 0);
      checkOutput("no_req_stays_idle", 32'(busy_out), 0);
      payload = '0;
      return;
    end
    payload = mData[w];
    checkOutput("ready_onehot", 32'(req_ready_out), 32'(1) << w);
    checkOutput("grant_id", 32'(grant_id_out), w);
    checkOutput("tx_valid_grant", 32'(tx_valid_out), 1);
    checkOutput("first_byte", 32'(tx_data_out), 32'(firstByte(w)));
    mPtr     = (w + 1) % N;
    mData[w] = B'($urandom);
    if (dropAfter) m[w] = 1'b0;
    applyStimulus(m);
  endtask

`ifdef UART_TX_ARB_ID_PREFIX_EN
  task automatic headerPhase(input logic [B-1:0] payload);
    tick();
    checkOutput("hdr_ready_cleared", 32'(req_ready_out), 0);
    checkOutput("hdr_valid_hold", 32'(tx_valid_out), 1);
    tx_done_in = 1'b1;
    tick();
    checkOutput("load_valid_low", 32'(tx_valid_out), 0);
    checkOutput("load_payload", 32'(tx_data_out), 32'(payload));
    tx_done_in = 1'b0;
    tick();
    checkOutput("send_after_load", 32'(tx_valid_out), 1);
  endtask
`endif

  // Called in the first GAP cycle; counts GAP cycles until IDLE is seen.
  task automatic waitGap(input int startLen, input int holdCyc);
    int len;
    int hi;
    len = startLen;
    hi  = 1;
    while (busy_out === 1'b1 && len <= GAP + 8) begin
      if (hi >= holdCyc) tx_done_in = 1'b0;
      tick();
      hi++;
      if (busy_out === 1'b1) begin
        len++;
        checkOutput("gap_valid_low", 32'(tx_valid_out), 0);
      end
    end
    checkOutput("gap_length", len, GAP);
    checkOutput("gap_to_idle", 32'(busy_out), 0);
    checkOutput("gap_no_err", 32'(timeout_err_out), 0);
  endtask

  task automatic finishFrame(input int waitCyc, input int holdCyc, input logic [B-1:0] payload);
    for (int c = 0; c < waitCyc; c++) begin
      tick();
      checkOutput("send_valid_hold", 32'(tx_valid_out), 1);
      checkOutput("send_data_hold", 32'(tx_data_out), 32'(payload));
      checkOutput("ready_single_pulse", 32'(req_ready_out), 0);
    end
    tx_done_in = 1'b1;
    tick();
    checkOutput("done_ends_frame", 32'(tx_valid_out), 0);
    checkOutput("done_no_err", 32'(timeout_err_out), 0);
    checkOutput("gap_busy", 32'(busy_out), 1);
    checkOutput("gap_data_kept", 32'(tx_data_out), 32'(payload));
    waitGap(1, holdCyc);
  endtask

  task automatic doFrame(input logic [N-1:0] mask, input bit drop, input int waitCyc, input int holdCyc);
    int           w;
    logic [B-1:0] p;
    grantStep(mask, drop, w, p);
    if (w >= 0) begin
`ifdef UART_TX_ARB_ID_PREFIX_EN
      headerPhase(p);
`endif
      finishFrame(waitCyc, holdCyc, p);
    end
  endtask

  task automatic checkResetState(input string phase);
    checkOutput({phase, "_ready"}, 32'(req_ready_out), 0);
    checkOutput({phase, "_valid"}, 32'(tx_valid_out), 0);
    checkOutput({phase, "_data"}, 32'(tx_data_out), 0);
    checkOutput({phase, "_grant_id"}, 32'(grant_id_out), 0);
    checkOutput({phase, "_busy"}, 32'(busy_out), 0);
    checkOutput({phase, "_err"}, 32'(timeout_err_out), 0);
  endtask

  initial begin
    int           w;
    int           len;
    logic [B-1:0] p;

    for (int i = 0; i < N; i++) mData[i] = B'($urandom);
    reset       = 1'b1;
    tx_done_in  = 1'b0;
    applyStimulus('0);
    tick();
    tick();
    checkResetState("reset");
    reset = 1'b0;
    mPtr  = 0;

    $display("[TB] fairness: all requesters held valid");
    for (int f = 0; f < 6; f++) doFrame(4'b1111, 1'b0, 1, 1);

    $display("[TB] single request from requester 2");
    mData[2] = 8'hA5;
    doFrame(4'b0100, 1'b1, 3, 1);

    $display("[TB] done held high across frames");
    doFrame(4'b0001, 1'b1, 1, 25);
    grantStep(4'b0100, 1'b1, w, p);
    repeat (3) begin
      tick();
      checkOutput("held_done_no_complete", 32'(tx_valid_out), 1);
    end
    tx_done_in = 1'b0;
`ifdef UART_TX_ARB_ID_PREFIX_EN
    headerPhase(p);
`endif
    finishFrame(1, 1, p);

    $display("[TB] randomized request patterns");
    for (int f = 0; f < 14; f++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(0, 15));
      doFrame(m, 1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(1, 5));
    end

    $display("[TB] stalled transmitter");
    grantStep(4'b1000, 1'b1, w, p);
    len = 1;
    while (tx_valid_out === 1'b1 && len <= TO + 8) begin
      tick();
      if (tx_valid_out === 1'b1) len++;
    end
    checkOutput("timeout_len", len, TO);
    checkOutput("timeout_err_pulse", 32'(timeout_err_out), 1);
    checkOutput("timeout_busy_gap", 32'(busy_out), 1);
    tick();
    checkOutput("timeout_err_once", 32'(timeout_err_out), 0);
    waitGap(2, 1);
    doFrame(4'b0010, 1'b1, 2, 1);

    $display("[TB] done on the timeout terminal cycle");
    grantStep(4'b0001, 1'b1, w, p);
    repeat (TO - 1) tick();
    checkOutput("terminal_still_valid", 32'(tx_valid_out), 1);
    tx_done_in = 1'b1;
    tick();
    checkOutput("terminal_done_no_err", 32'(timeout_err_out), 0);
    checkOutput("terminal_done_valid_low", 32'(tx_valid_out), 0);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    tx_done_in = 1'b0;
    tick();
    checkOutput("terminal_send_payload", 32'(tx_data_out), 32'(p));
    finishFrame(1, 1, p);
`else
    waitGap(1, 1);
`endif

    $display("[TB] reset in the middle of a frame");
    grantStep(4'b0010, 1'b1, w, p);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkResetState("midreset");
    reset = 1'b0;
    mPtr  = 0;
    doFrame(4'b1111, 1'b1, 2, 1);

    $display("[TB] no requests keeps the arbiter idle");
    doFrame(4'b0000, 1'b0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance between NUM_REQ byte requesters using round-robin arbitration. The block owns the TX handshake: it latches the winner's byte, drives valid_tx_in/data_tx_in of uart_tx, and waits for the frame-complete indication (ready_tx_out). It enforces an inter-frame gap and detects a stalled transmitter with a timeout. It sits between the protocol/command blocks and uart_tx.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
BYTESIZES, 8, data width per frame; must match uart_tx
GAP_CYCLES, 16, idle cycles after each frame before the next grant (0 allowed)
TIMEOUT_CYCLES, 100000, maximum cycles to wait for frame completion before aborting

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
req_valid_in  in  NUM_REQ  per-requester request; held with data until accepted
req_data_in  in  NUM_REQ*BYTESIZES  packed bytes; requester i uses bits [i*BYTESIZES +: BYTESIZES]
req_ready_out  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester
tx_valid_out  out  1  to uart_tx valid_tx_in
tx_data_out  out  BYTESIZES  to uart_tx data_tx_in
tx_done_in  in  1  from uart_tx ready_tx_out; level, may stay high for several cycles
grant_id_out  out  $clog2(NUM_REQ) (min 1)  index of the last granted requester
busy_out  out  1  high whenever state != IDLE
timeout_err_out  out  1  one-cycle pulse when a frame is aborted on timeout

Behaviour:
- Reset (synchronous, active-high): state IDLE; tx_valid_out=0; tx_data_out=0; req_ready_out=0; grant_id_out=0; busy_out=0; timeout_err_out=0; RR pointer=0; gap and timeout counters=0; done-edge register=0.
- Done detection: done_rise = tx_done_in & ~tx_done_q, where tx_done_q is a registered copy. Only rising edges complete a frame.
- Arbitration: in IDLE, search from the RR pointer upward with wrap-around. The first i with req_valid_in[i]=1 wins.
- Grant cycle: latch the winner's data into tx_data_out, pulse req_ready_out[winner] for exactly 1 cycle, set grant_id_out=winner, set the RR pointer to (winner+1) mod NUM_REQ, then move to SEND. Grant latency is 1 cycle from a valid request observed in IDLE.
- A requester dropping req_valid_in before it is granted is legal. It is not granted and the pointer does not move.
- States:
  - IDLE: no request -> stay in IDLE; any request -> grant -> SEND (or HDR when the optional feature is enabled).
  - HDR: tx_valid_out=1 with the header byte. done_rise -> LOAD; timeout -> GAP.
  - LOAD: tx_valid_out=0 for 1 cycle and the payload byte is driven -> SEND.
  - SEND: tx_valid_out=1; tx_data_out holds steady. done_rise -> GAP; timeout -> GAP.
  - GAP: tx_valid_out=0; count GAP_CYCLES cycles -> IDLE. With GAP_CYCLES=0, GAP lasts exactly 1 cycle.
- Timeout: the counter clears on entry to HDR and to SEND and increments each cycle in those states. When it reaches TIMEOUT_CYCLES-1 with no done_rise: drop tx_valid_out, pulse timeout_err_out, go to GAP, and discard the byte.
- If done_rise and the timeout terminal count occur in the same cycle, done wins and no error is raised.
- A done_rise seen in IDLE, LOAD or GAP is ignored.
- Counter widths are $clog2(TIMEOUT_CYCLES+1) and $clog2(GAP_CYCLES+1). Neither counter wraps; each saturates at its terminal count.
- Reset mid-frame returns to the reset state immediately. A byte that was already accepted is lost and the requester is not notified.
- NUM_REQ=1: the arbiter degenerates to a pass-through sequencer and grant_id_out stays 0.

Optional Feature:
UART_TX_ARB_ID_PREFIX_EN
- Defined: each grant sends a header frame before the payload. The header byte is {1'b1, zero-extended grant index} truncated to BYTESIZES bits. Sequence is HDR -> LOAD -> SEND.
- Undefined: the HDR and LOAD states are absent and the grant goes directly to SEND. Only the payload frame is sent.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef arb_state_t {IDLE, HDR, LOAD, SEND, GAP};
  - the header MSB marker constant;
  - the shared BYTESIZES default.
- One sub-module, rr_arbiter: combinational round-robin winner search taking (req, pointer) and returning (grant one-hot, found, index). It is reusable by other shared-resource blocks.

Test Plan:
- Single request: req_valid_in=4'b0100, data[2]=8'hA5 -> ready pulse on bit 2 one cycle after; tx_valid_out=1 with tx_data_out=8'hA5 until tx_done_in rises; then 16 GAP cycles, then IDLE; grant_id_out=2.
- Fairness: all four requesters continuously valid -> grant order 0,1,2,3,0,1, each followed by exactly one req_ready_out pulse.
- Done held high 5 cycles at frame end -> exactly one frame completes and no spurious second completion.
- Stalled TX: tx_done_in tied 0 with TIMEOUT_CYCLES=50 -> tx_valid_out drops after 50 cycles, timeout_err_out pulses once, then GAP and next grant. Also drive done_rise on the terminal cycle -> no error pulse.
- Reset asserted mid-SEND -> next cycle all outputs at reset values and pointer=0; after release, requester 0 is granted first.
- With UART_TX_ARB_ID_PREFIX_EN and requester 3 sending 8'h3C -> frames 8'h83 then 8'h3C, with one LOAD cycle of tx_valid_out=0 between them.
